// File: rtl/obstacle_generator.sv
// obstacle_generator: spawns, scrolls and retires up to N_OBS obstacles per frame,
// ramping scroll speed with play time and scoring each obstacle that leaves the screen.
module obstacle_generator #(
    parameter int          N_OBS             = 10,
    parameter int          SCREEN_W          = 640,
    parameter int          OBS_WIDTH         = 40,
    parameter int          UPPER_BOUND       = 20,
    parameter int          LOWER_BOUND       = 460,
    parameter int          MIN_HEIGHT        = 40,
    parameter int          MAX_HEIGHT        = 160,
    parameter int          BASE_SPEED        = 2,
    parameter int          MAX_SPEED         = 8,
    parameter int          SPEED_STEP_FRAMES = 600,
    parameter int          SPAWN_INTERVAL    = 60,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           gamemode,
    output logic [N_OBS*10-1:0]  obstacle_x_left,
    output logic [N_OBS*10-1:0]  obstacle_x_right,
    output logic [N_OBS*9-1:0]   obstacle_y_up,
    output logic [N_OBS*9-1:0]   obstacle_y_down,
    output logic [3:0]           speed,
    output logic [15:0]          score,
    output logic                 spawn_drop
);
    localparam int SCW = $clog2(SPAWN_INTERVAL + 1);
    localparam int SPW = $clog2(SPEED_STEP_FRAMES + 1);

    logic [N_OBS-1:0] active, retire, spawn_sel;
    logic [9:0]       xl [N_OBS];
    logic [9:0]       xr [N_OBS];
    logic [8:0]       yu [N_OBS];
    logic [8:0]       yd [N_OBS];
    logic [15:0]      lfsr, lfsr_next, score_next;
    logic [16:0]      score_sum;
    logic [SCW-1:0]   spawn_cnt;
    logic [SPW-1:0]   speed_cnt;
    logic             spawn_now, step_now;
    logic [9:0]       spd, h_raw, h, room, off, y_up_new, y_down_new;

    always_comb begin
        lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        spd        = {6'd0, speed};
        spawn_now  = spawn_cnt == SCW'(SPAWN_INTERVAL - 1);
        step_now   = speed_cnt == SPW'(SPEED_STEP_FRAMES - 1);
        // lowest inactive slot as a one-hot; all zero when every slot is busy
        spawn_sel  = ~active & (active + 1'b1);
        h_raw      = 10'(MIN_HEIGHT) + {3'd0, lfsr[6:0]};
        h          = (h_raw > 10'(MAX_HEIGHT)) ? 10'(MAX_HEIGHT) : h_raw;
        room       = 10'(LOWER_BOUND - UPPER_BOUND) - h;
        off        = {2'd0, lfsr[15:8]};
        y_up_new   = (lfsr[9:8] == 2'b00) ? 10'(UPPER_BOUND) :
                     (lfsr[9:8] == 2'b01) ? 10'(LOWER_BOUND) - h :
                     10'(UPPER_BOUND) + ((off < room) ? off : room);
        y_down_new = y_up_new + h;
        retire     = '0;
        for (int i = 0; i < N_OBS; i++)
            retire[i] = active[i] && (xr[i] <= spd);
        score_sum  = {1'b0, score} + 17'($countones(retire));
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst || gamemode == 2'b00) begin
            for (int i = 0; i < N_OBS; i++) begin
                xl[i] <= '0;
                xr[i] <= '0;
                yu[i] <= '0;
                yd[i] <= '0;
            end
            active     <= '0;
            speed      <= 4'(BASE_SPEED);
            score      <= '0;
            spawn_cnt  <= '0;
            speed_cnt  <= '0;
            spawn_drop <= 1'b0;
            lfsr       <= rst ? LFSR_SEED : lfsr_next;
        end else if (gamemode == 2'b01) begin
            lfsr       <= lfsr_next;
            spawn_cnt  <= spawn_now ? '0 : spawn_cnt + 1'b1;
            speed_cnt  <= step_now ? '0 : speed_cnt + 1'b1;
            speed      <= (step_now && speed < 4'(MAX_SPEED)) ? speed + 4'd1 : speed;
            score      <= score_next;
            spawn_drop <= spawn_now && !(|spawn_sel);
            for (int i = 0; i < N_OBS; i++) begin
                if (retire[i]) begin
                    active[i] <= 1'b0;
                    xl[i]     <= '0;
                    xr[i]     <= '0;
                    yu[i]     <= '0;
                    yd[i]     <= '0;
                end else if (active[i]) begin
                    xr[i] <= xr[i] - spd;
                    xl[i] <= (xl[i] > spd) ? xl[i] - spd : '0;
                end else if (spawn_now && spawn_sel[i]) begin
                    active[i] <= 1'b1;
                    xl[i]     <= 10'(SCREEN_W);
                    xr[i]     <= 10'(SCREEN_W + OBS_WIDTH);
                    yu[i]     <= 9'(y_up_new);
                    yd[i]     <= 9'(y_down_new);
                end
            end
        end else begin
            spawn_drop <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_OBS; g++) begin : g_pack
        assign obstacle_x_left[g*10 +: 10]  = xl[g];
        assign obstacle_x_right[g*10 +: 10] = xr[g];
        assign obstacle_y_up[g*9 +: 9]      = yu[g];
        assign obstacle_y_down[g*9 +: 9]    = yd[g];
    end
endmodule

// File: tb/tb_obstacle_generator.sv
// tb_obstacle_generator: checks obstacle_generator against a frame-level model every cycle,
// plus literal checks for spawn timing, retirement, speed ramp, slot exhaustion and mode handling.
module tb_obstacle_generator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  gamemode = 2'b00;
    logic [99:0] xl_o, xr_o, f_xl, f_xr;
    logic [89:0] yu_o, yd_o, f_yu, f_yd;
    logic [3:0]  speed_o, f_speed;
    logic [15:0] score_o, f_score;
    logic        drop_o, f_drop;
    int          tests = 0, failed = 0, pf = 0;

    always #5 clk = ~clk;

    obstacle_generator dut (
        .clk(clk), .rst(rst), .gamemode(gamemode),
        .obstacle_x_left(xl_o), .obstacle_x_right(xr_o),
        .obstacle_y_up(yu_o), .obstacle_y_down(yd_o),
        .speed(speed_o), .score(score_o), .spawn_drop(drop_o)
    );

    obstacle_generator #(.SPAWN_INTERVAL(1), .OBS_WIDTH(300)) u_fill (
        .clk(clk), .rst(rst), .gamemode(gamemode),
        .obstacle_x_left(f_xl), .obstacle_x_right(f_xr),
        .obstacle_y_up(f_yu), .obstacle_y_down(f_yd),
        .speed(f_speed), .score(f_score), .spawn_drop(f_drop)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s pf=%0d got=%h exp=%h", name, pf, got, exp);
        end
    endtask

    // frame-level model: speed and spawn timing derive from the total play-frame count
    int          m_xl[10], m_xr[10], m_yu[10], m_yd[10];
    bit          m_act[10];
    int          m_speed, m_score, m_frames;
    bit          m_drop, m_valid;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 10; i++) begin
            m_act[i] = 0; m_xl[i] = 0; m_xr[i] = 0; m_yu[i] = 0; m_yd[i] = 0;
        end
        m_speed = 2; m_score = 0; m_frames = 0; m_drop = 0;
    endtask

    task automatic m_play();
        int free = -1, spd = m_speed, gone = 0, h, off;
        logic [15:0] l = m_lfsr;
        for (int i = 0; i < 10; i++) if (!m_act[i] && free < 0) free = i;
        for (int i = 0; i < 10; i++) begin
            if (!m_act[i]) continue;
            if (m_xr[i] <= spd) begin
                m_act[i] = 0; m_xl[i] = 0; m_xr[i] = 0; m_yu[i] = 0; m_yd[i] = 0; gone++;
            end else begin
                m_xr[i] -= spd;
                m_xl[i] = (m_xl[i] > spd) ? m_xl[i] - spd : 0;
            end
        end
        m_frames++;
        m_drop = 0;
        if (m_frames % 60 == 0) begin
            if (free < 0) m_drop = 1;
            else begin
                h = 40 + int'(l[6:0]);
                if (h > 160) h = 160;
                if (l[9:8] == 2'b00) begin m_yu[free] = 20; m_yd[free] = 20 + h; end
                else if (l[9:8] == 2'b01) begin m_yd[free] = 460; m_yu[free] = 460 - h; end
                else begin
                    off = int'(l[15:8]);
                    m_yu[free] = 20 + ((off < 440 - h) ? off : 440 - h);
                    m_yd[free] = m_yu[free] + h;
                end
                m_xl[free] = 640; m_xr[free] = 680; m_act[free] = 1;
            end
        end
        m_speed = 2 + m_frames / 600;
        if (m_speed > 8) m_speed = 8;
        m_score = (m_score + gone > 65535) ? 65535 : m_score + gone;
        m_lfsr = lstep(l);
    endtask

    always @(posedge clk) begin
        if (rst) begin m_clear(); m_lfsr = 16'hACE1; m_valid = 1; end
        else if (m_valid && gamemode == 2'b00) begin m_clear(); m_lfsr = lstep(m_lfsr); end
        else if (m_valid && gamemode == 2'b01) m_play();
        else m_drop = 0;
    end

    always @(negedge clk) begin
        logic [99:0] exl, exr;
        logic [89:0] eyu, eyd;
        if (m_valid) begin
            for (int i = 0; i < 10; i++) begin
                exl[i*10 +: 10] = 10'(m_xl[i]);
                exr[i*10 +: 10] = 10'(m_xr[i]);
                eyu[i*9 +: 9]   = 9'(m_yu[i]);
                eyd[i*9 +: 9]   = 9'(m_yd[i]);
            end
            check("model_x_left", 128'(xl_o), 128'(exl));
            check("model_x_right", 128'(xr_o), 128'(exr));
            check("model_y_up", 128'(yu_o), 128'(eyu));
            check("model_y_down", 128'(yd_o), 128'(eyd));
            check("model_speed", 128'(speed_o), 128'(m_speed));
            check("model_score", 128'(score_o), 128'(m_score));
            check("model_drop", 128'(drop_o), 128'(m_drop));
            check("model_lfsr", 128'(dut.lfsr), 128'(m_lfsr));
        end
    end

    task automatic frames(input int n);
        repeat (n) begin @(negedge clk); pf++; end
    endtask

    initial begin
        @(negedge clk);
        check("rst_x_left", 128'(xl_o), 128'(0));
        check("rst_speed", 128'(speed_o), 128'(2));
        check("rst_score", 128'(score_o), 128'(0));
        check("rst_drop", 128'(drop_o), 128'(0));
        check("rst_lfsr", 128'(dut.lfsr), 128'(16'hACE1));
        rst = 1'b0; gamemode = 2'b01;
        frames(1);
        check("lfsr_first_step", 128'(dut.lfsr), 128'(16'hE270));
        frames(9);
        for (int i = 0; i < 10; i++) begin
            check("fill_x_left", 128'(f_xl[i*10 +: 10]), 128'(640 - 2 * (9 - i)));
            check("fill_x_right", 128'(f_xr[i*10 +: 10]), 128'(940 - 2 * (9 - i)));
        end
        check("fill_no_drop_yet", 128'(f_drop), 128'(0));
        frames(1);
        check("fill_drop", 128'(f_drop), 128'(1));
        check("fill_slot9_moved", 128'(f_xl[90 +: 10]), 128'(638));
        check("fill_slot0_moved", 128'(f_xl[0 +: 10]), 128'(620));
        frames(48);
        check("no_spawn_59_xl", 128'(xl_o), 128'(0));
        check("no_spawn_59_xr", 128'(xr_o), 128'(0));
        frames(1);
        check("spawn_x_left", 128'(xl_o[9:0]), 128'(640));
        check("spawn_x_right", 128'(xr_o[9:0]), 128'(680));
        check("spawn_ydown_bound", 128'(yd_o[8:0] <= 9'd460), 128'(1));
        check("spawn_height", 128'((yd_o[8:0] - yu_o[8:0] >= 9'd40) && (yd_o[8:0] - yu_o[8:0] <= 9'd160)), 128'(1));
        check("spawn_slot1_empty", 128'(xl_o[19:10]), 128'(0));
        frames(339);
        check("pre_retire_xr", 128'(xr_o[9:0]), 128'(2));
        check("pre_retire_score", 128'(score_o), 128'(0));
        frames(1);
        check("retire_xr", 128'(xr_o[9:0]), 128'(0));
        check("retire_yu", 128'(yu_o[8:0]), 128'(0));
        check("retire_score", 128'(score_o), 128'(1));
        frames(199);
        check("speed_599", 128'(speed_o), 128'(2));
        frames(1);
        check("speed_600", 128'(speed_o), 128'(3));
        frames(100);
        check("score_700", 128'(score_o), 128'(6));
        gamemode = 2'b10;
        repeat (100) begin
            @(negedge clk);
            check("pause_drop", 128'(drop_o), 128'(0));
        end
        check("pause_score", 128'(score_o), 128'(6));
        check("pause_speed", 128'(speed_o), 128'(3));
        gamemode = 2'b01;
        frames(2900);
        check("speed_3600", 128'(speed_o), 128'(8));
        frames(100);
        check("speed_ceiling", 128'(speed_o), 128'(8));
        gamemode = 2'b00;
        @(negedge clk);
        check("clear_xl", 128'(xl_o), 128'(0));
        check("clear_score", 128'(score_o), 128'(0));
        check("clear_speed", 128'(speed_o), 128'(2));
        check("clear_lfsr_not_seed", 128'(dut.lfsr != 16'hACE1), 128'(1));
        gamemode = 2'b01; pf = 0;
        frames(70);
        check("replay_spawned", 128'(xr_o[9:0] != 10'd0), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rerst_lfsr", 128'(dut.lfsr), 128'(16'hACE1));
        check("rerst_xr", 128'(xr_o), 128'(0));
        rst = 1'b0;
        frames(5);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
